uart_rx_buffered: RTL and testbench
===================================

# uart_rx_buffered

Oversampling UART receiver with runtime baud/frame configuration, majority-vote sampling, per-byte error flags, break detection and an output FIFO with a valid/ready handshake. It is the successor to the single-register fixed-parameter receiver, and sits between the pad-side `rx` pin and the bus-side peripheral register block. Decoded bytes can be drained at the consumer's pace instead of being overwritten by the next frame.

## Interface
- `data_bits`, 8: character width, range 5-9.
- `oversample`, 16: ticks per bit, even, range 8-16.
- `div_width`, 16: width of `cfg_div`.
- `fifo_depth`, 16: entries, power of two, at least 2.
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input, idle high.
- `cfg_div`  in  div_width  clk cycles per oversample tick; 0 is treated as 1.
- `cfg_parity`  in  2  0 = none, 1 = odd, 2 = even, 3 = none.
- `cfg_stop2`  in  1  1 = two stop bits checked.
- `rx_data`  out  data_bits  head entry data.
- `rx_parity_err`, `rx_frame_err`, `rx_break`  out  1 each  head entry flags.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pop; a pop occurs when `rx_valid && rx_ready`.
- `rx_count`  out  $clog2(fifo_depth)+1  FIFO occupancy.
- `rx_overrun`  out  1  sticky: an entry was dropped because the FIFO was full.
- `ovr_clr`  in  1  clears `rx_overrun`.

## Operation
- **Input synchronizer:** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized value.
- **Tick generator:** a divider counts 0..max(cfg_div,1)-1 and emits a 1-cycle tick at terminal count. It free-runs in IDLE and restarts at 0 on start-edge detection.
- **Config latching:** `cfg_*` are latched on start-edge detection. Changes during a frame have no effect until the next frame.
- **Bit sampling:** each bit uses a tick counter 0..oversample-1. Samples are taken at ticks oversample/2-1, oversample/2 and oversample/2+1. The bit value is the 2-of-3 majority, decided at tick oversample/2+1.
- **States:** IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - **IDLE:** synchronized rx = 0 → START.
  - **START:** majority 1 → IDLE (glitch rejected, no entry). Majority 0 → DATA.
  - **DATA:** data_bits bits, LSB first. Then PARITY if parity is enabled, else STOP.
  - **PARITY:** odd mode errors when the XOR of data and parity bit is 0; even mode errors when it is 1.
  - **STOP:** majority 0 sets the frame error. With `cfg_stop2`, a second stop bit is sampled; either bit low sets the frame error.
  - **STOP exit:** after the last stop decision, push the entry {break, frame, parity, data}. Go to BRK_WAIT if break, else IDLE. The transition happens mid-stop-bit to allow resync.
- **Break condition:** data all 0, parity bit 0 (when enabled) and first stop bit 0. A break entry has `rx_break` = 1, `rx_frame_err` = 1 and data = 0.
  - BRK_WAIT → IDLE once the synchronized rx = 1 for a full bit time.
  - Exactly one entry is pushed per break.
- **FIFO:**
  - A push is accepted if count < fifo_depth, or if a pop happens in the same cycle.
  - Otherwise the entry is dropped, `rx_overrun` is set and FIFO contents are unchanged.
  - `ovr_clr` takes priority over a same-cycle set.
  - When `rx_valid` = 0, `rx_data` and all flags read 0.
- **Reset:** the state machine goes to IDLE and the FIFO is emptied.
  - `rx_valid` = 0, `rx_count` = 0, `rx_overrun` = 0, and data/flags read 0.
  - A frame in progress when reset asserts is discarded.

## Timing
- Push occurs on the clk after the last stop bit's tick oversample/2+1. `rx_valid` / `rx_count` update on the following cycle.
- Pop: the head advances on the cycle after `rx_valid && rx_ready`. Back-to-back pops are allowed every cycle.
- Simultaneous push and pop: the count is unchanged. When full, both are accepted with no overrun.
- Start detection latency: 2 cycles of synchronizer plus 1 cycle.
- Tolerated baud mismatch: about ±3% at oversample 16.

## Structure
- **Package `uart_pkg`:**
  - `rx_state_e` enum.
  - `parity_e` enum (NONE, ODD, EVEN).
  - `rx_entry_t` packed struct {break, frame_err, parity_err, data[8:0]}, sized for the maximum of 9 data bits; unused MSBs are 0.
- **Sub-module `sync_fifo`:**
  - Parameters: width, depth.
  - Ports: push/pop, full/empty, count.
  - Read data is combinational from the head.

## Test plan
- **Single 8N1 byte:** `cfg_div`=27 at 50 MHz with oversample 16 (about 115.7 kbaud); send 0xA5 → one entry 0xA5, all flags 0, `rx_count`=1.
- **Even parity:** 0x03 sent with parity bit 1 → `rx_parity_err`=1. Resend with parity bit 0 → flag 0.
- **Glitch and noise:** rx low for 3 ticks in IDLE → no entry, back to IDLE. A single-tick inverted pulse inside bit 4 of 0x00 → data 0x00, since majority vote masks it.
- **Framing and break:**
  - 0x55 with stop bit low → `rx_frame_err`=1, `rx_break`=0.
  - rx held low for 20 bit times → exactly one entry with break=1, data=0; the next valid frame decodes correctly.
- **Overrun:** depth 4, `rx_ready`=0, send 0x01..0x05 → count=4, overrun=1. Drain returns 0x01..0x04. `ovr_clr` → overrun=0.
- **Full boundary and reset:**
  - FIFO full with `rx_ready`=1 held during a push → no overrun, count stays 4.
  - Reset asserted mid-DATA → outputs return to their reset values, and the next frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_buffered_pkg.sv
// Shared types for the buffered UART receiver: FSM state codes, parity modes
// and the FIFO entry layout (sized for the widest 9-bit character).
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE     = 3'd0,
        RX_START    = 3'd1,
        RX_DATA     = 3'd2,
        RX_PARITY   = 3'd3,
        RX_STOP     = 3'd4,
        RX_BRK_WAIT = 3'd5
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef struct packed {
        logic       brk;
        logic       frame_err;
        logic       parity_err;
        logic [8:0] data;
    } rx_entry_t;

    // Encoding 3 is a second spelling of "no parity".
    function automatic parity_e decode_parity(input logic [1:0] cfg);
        case (cfg)
            2'd1:    return PAR_ODD;
            2'd2:    return PAR_EVEN;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// Single-clock FIFO with combinational head read; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with 2-of-3 majority sampling, per-byte error and
// break flags, and an output FIFO drained through a valid/ready handshake.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int data_bits  = 8,
    parameter int oversample = 16,
    parameter int div_width  = 16,
    parameter int fifo_depth = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx,
    input  logic [div_width-1:0]          cfg_div,
    input  logic [1:0]                    cfg_parity,
    input  logic                          cfg_stop2,
    output logic [data_bits-1:0]          rx_data,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          rx_break,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(fifo_depth):0]   rx_count,
    output logic                          rx_overrun,
    input  logic                          ovr_clr
);
    localparam int TW = $clog2(oversample);
    localparam int BW = $clog2(data_bits);
    localparam logic [TW-1:0] T_S0   = TW'(oversample/2 - 1);
    localparam logic [TW-1:0] T_S1   = TW'(oversample/2);
    localparam logic [TW-1:0] T_DEC  = TW'(oversample/2 + 1);
    localparam logic [TW-1:0] T_LAST = TW'(oversample - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [BW-1:0] B_LAST = BW'(data_bits - 1);
    localparam logic [BW-1:0] B_ONE  = BW'(1);
    localparam logic [div_width-1:0] DIV_ONE = div_width'(1);

    localparam logic [2:0] S_IDLE     = 3'(RX_IDLE);
    localparam logic [2:0] S_START    = 3'(RX_START);
    localparam logic [2:0] S_DATA     = 3'(RX_DATA);
    localparam logic [2:0] S_PARITY   = 3'(RX_PARITY);
    localparam logic [2:0] S_STOP     = 3'(RX_STOP);
    localparam logic [2:0] S_BRK_WAIT = 3'(RX_BRK_WAIT);

    logic                 rx_meta, rx_sync;
    logic [2:0]           state;
    logic [div_width-1:0] div_cnt, div_lat, div_sel, div_max;
    logic [TW-1:0]        tick_cnt;
    parity_e              par_lat;
    logic                 stop2_lat;
    logic [BW-1:0]        bit_idx;
    logic [8:0]           data_sr;
    logic                 samp0, samp1;
    logic                 all_zero, frame_err, par_err, brk_flag, second_stop;
    logic                 tick, start_edge, decide, bit_val;
    logic                 par_bad, stop_frame, stop_brk, last_stop;
    logic                 push_req, pop, drop, fifo_full, fifo_empty;
    rx_entry_t            push_entry, head;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running on the live divisor while idle, on the latched one mid-frame.
    assign div_sel    = (state == S_IDLE) ? cfg_div : div_lat;
    assign div_max    = (div_sel == '0) ? DIV_ONE : div_sel;
    assign tick       = (div_cnt >= div_max - DIV_ONE);
    assign start_edge = (state == S_IDLE) && !rx_sync;
    assign decide     = tick && (tick_cnt == T_DEC);
    assign bit_val    = (samp0 & samp1) | (samp0 & rx_sync) | (samp1 & rx_sync);

    assign par_bad    = (par_lat == PAR_ODD) ? ~(^data_sr ^ bit_val) : (^data_sr ^ bit_val);
    assign stop_frame = frame_err | ~bit_val;
    assign stop_brk   = second_stop ? brk_flag : (all_zero & ~bit_val);
    assign last_stop  = second_stop | ~stop2_lat;

    always_ff @(posedge clk) begin
        if (rst || start_edge || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + DIV_ONE;
    end

    // In BRK_WAIT the tick counter doubles as the "line high for a bit" timer.
    always_ff @(posedge clk) begin
        if (rst || start_edge)
            tick_cnt <= '0;
        else if (state == S_BRK_WAIT && !rx_sync)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + T_ONE;
        if (tick && tick_cnt == T_S0)
            samp0 <= rx_sync;
        if (tick && tick_cnt == T_S1)
            samp1 <= rx_sync;
    end

    always_ff @(posedge clk) begin
        push_req <= 1'b0;
        if (rst) begin
            state       <= S_IDLE;
            div_lat     <= '0;
            par_lat     <= PAR_NONE;
            stop2_lat   <= 1'b0;
            bit_idx     <= '0;
            data_sr     <= '0;
            all_zero    <= 1'b0;
            frame_err   <= 1'b0;
            par_err     <= 1'b0;
            brk_flag    <= 1'b0;
            second_stop <= 1'b0;
            push_entry  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_edge) begin
                    state     <= S_START;
                    div_lat   <= cfg_div;
                    par_lat   <= decode_parity(cfg_parity);
                    stop2_lat <= cfg_stop2;
                end
                S_START: if (decide) begin
                    state       <= bit_val ? S_IDLE : S_DATA;
                    bit_idx     <= '0;
                    data_sr     <= '0;
                    all_zero    <= 1'b1;
                    frame_err   <= 1'b0;
                    par_err     <= 1'b0;
                    brk_flag    <= 1'b0;
                    second_stop <= 1'b0;
                end
                S_DATA: if (decide) begin
                    data_sr[bit_idx] <= bit_val;
                    all_zero         <= all_zero & ~bit_val;
                    if (bit_idx == B_LAST) begin
                        bit_idx <= '0;
                        state   <= (par_lat == PAR_NONE) ? S_STOP : S_PARITY;
                    end else begin
                        bit_idx <= bit_idx + B_ONE;
                    end
                end
                S_PARITY: if (decide) begin
                    par_err  <= par_bad;
                    all_zero <= all_zero & ~bit_val;
                    state    <= S_STOP;
                end
                // Leaves mid-stop-bit so the next start edge can be caught early.
                S_STOP: if (decide) begin
                    frame_err <= stop_frame;
                    brk_flag  <= stop_brk;
                    if (last_stop) begin
                        push_req   <= 1'b1;
                        push_entry <= '{brk:        stop_brk,
                                        frame_err:  stop_frame | stop_brk,
                                        parity_err: par_err & ~stop_brk,
                                        data:       stop_brk ? 9'd0 : data_sr};
                        state      <= stop_brk ? S_BRK_WAIT : S_IDLE;
                    end else begin
                        second_stop <= 1'b1;
                    end
                end
                S_BRK_WAIT: if (tick && rx_sync && tick_cnt == T_LAST)
                    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign pop  = rx_valid && rx_ready;
    assign drop = push_req && fifo_full && !pop;

    sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_req),
        .push_data (push_entry),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    always_ff @(posedge clk) begin
        if (rst || ovr_clr)
            rx_overrun <= 1'b0;
        else if (drop)
            rx_overrun <= 1'b1;
    end

    assign rx_valid      = !fifo_empty;
    assign rx_data       = rx_valid ? head.data[data_bits-1:0] : '0;
    assign rx_parity_err = rx_valid & head.parity_err;
    assign rx_frame_err  = rx_valid & head.frame_err;
    assign rx_break      = rx_valid & head.brk;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: table-driven frames, hand-written
// corner sequences and randomized frames scored against a frame-level model.
module tb_uart_rx_buffered;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, rx, rx_ready, ovr_clr, cfg_stop2;
    logic [15:0] cfg_div;
    logic [1:0]  cfg_parity;
    logic [7:0]  rx_data;
    logic        rx_parity_err, rx_frame_err, rx_break, rx_valid, rx_overrun;
    logic [2:0]  rx_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .data_bits  (8),
        .oversample (OS),
        .div_width  (16),
        .fifo_depth (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx            (rx),
        .cfg_div       (cfg_div),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .rx_data       (rx_data),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_break      (rx_break),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .rx_overrun    (rx_overrun),
        .ovr_clr       (ovr_clr)
    );

    typedef struct {
        logic [7:0]  data;
        logic [1:0]  par_mode;
        logic        par_bit;
        logic        stop1;
        logic        stop2_en;
        logic        stop2;
        logic [15:0] div;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
        logic        exp_brk;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mkVec(logic [7:0] d, logic [1:0] m, logic pb, logic s1,
                                   logic s2en, logic s2, logic [15:0] dv,
                                   logic [7:0] ed, logic pe, logic fe, logic br);
        vec_t v;
        v.data = d; v.par_mode = m; v.par_bit = pb; v.stop1 = s1;
        v.stop2_en = s2en; v.stop2 = s2; v.div = dv;
        v.exp_data = ed; v.exp_perr = pe; v.exp_ferr = fe; v.exp_brk = br;
        return v;
    endfunction

    // Frame-level reference: what entry a cleanly transmitted frame must produce.
    function automatic vec_t withExpected(vec_t v);
        vec_t r = v;
        bit par_en = (v.par_mode == 2'd1) || (v.par_mode == 2'd2);
        int ones   = $countones(v.data) + (par_en && v.par_bit ? 1 : 0);
        bit brk    = (v.data == 8'd0) && (!par_en || !v.par_bit) && !v.stop1;
        r.exp_brk  = brk;
        r.exp_ferr = !v.stop1 || (v.stop2_en && !v.stop2) || brk;
        r.exp_perr = par_en && !brk && ((v.par_mode == 2'd1) ? (ones % 2 == 0) : (ones % 2 == 1));
        r.exp_data = brk ? 8'd0 : v.data;
        return r;
    endfunction

    function automatic int bitCycles(logic [15:0] dv);
        return OS * ((dv == 16'd0) ? 1 : int'(dv));
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic holdLine(logic v, int cycles);
        rx = v;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(vec_t v, int noise_bit);
        int bc;
        cfg_div    = v.div;
        cfg_parity = v.par_mode;
        cfg_stop2  = v.stop2_en;
        bc = bitCycles(v.div);
        @(posedge clk);
        #1;
        holdLine(1'b0, bc);
        for (int i = 0; i < 8; i++) begin
            if (i == noise_bit) begin
                holdLine(v.data[i], bc / 2);
                holdLine(~v.data[i], bc / OS);
                holdLine(v.data[i], bc - bc / 2 - bc / OS);
            end else begin
                holdLine(v.data[i], bc);
            end
        end
        if (v.par_mode == 2'd1 || v.par_mode == 2'd2)
            holdLine(v.par_bit, bc);
        holdLine(v.stop1, bc);
        if (v.stop2_en)
            holdLine(v.stop2, bc);
        holdLine(1'b1, 2 * bc);
    endtask

    task automatic popCheck(string tag, logic [7:0] ed, logic pe, logic fe, logic br);
        int n = 0;
        while (!rx_valid && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (!rx_valid) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_wait: rx_valid stayed 0, expected 1", tag);
            return;
        end
        @(negedge clk);
        checkOutput({tag, "_data"}, 32'(rx_data), 32'(ed));
        checkOutput({tag, "_flags(brk,fe,pe)"}, 32'({rx_break, rx_frame_err, rx_parity_err}),
                    32'({br, fe, pe}));
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic checkIdleOutputs(string tag);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 32'(rx_valid), 32'd0);
        checkOutput({tag, "_count"}, 32'(rx_count), 32'd0);
        checkOutput({tag, "_data_flags"},
                    32'({rx_data, rx_break, rx_frame_err, rx_parity_err}), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin : main
        vec_t v;
        int   seen;
        int   n;

        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
        cfg_div = 16'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        checkIdleOutputs("reset");
        checkOutput("reset_overrun", 32'(rx_overrun), 32'd0);

        //             data   par  pb    s1    s2en  s2    div     exp   pe    fe    brk
        vecs[0]  = mkVec(8'hA5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd27, 8'hA5, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mkVec(8'h03, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2,  8'h03, 1'b1, 1'b0, 1'b0);
        vecs[2]  = mkVec(8'h03, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2,  8'h03, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mkVec(8'h55, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2,  8'h55, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mkVec(8'h80, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2,  8'h80, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mkVec(8'h80, 2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 16'd2,  8'h80, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mkVec(8'h3C, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2,  8'h3C, 1'b0, 1'b1, 1'b0);
        vecs[7]  = mkVec(8'hC3, 2'd3, 1'b0, 1'b1, 1'b1, 1'b1, 16'd2,  8'hC3, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mkVec(8'h96, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0,  8'h96, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mkVec(8'h00, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2,  8'h00, 1'b0, 1'b0, 1'b0);
        vecs[10] = mkVec(8'h7E, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2,  8'h7E, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i], -1);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_count", i), 32'(rx_count), 32'd1);
            popCheck($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_perr,
                     vecs[i].exp_ferr, vecs[i].exp_brk);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_count_after_pop", i), 32'(rx_count), 32'd0);
        end

        // Three-tick low glitch while idle must not produce an entry.
        cfg_div = 16'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        @(posedge clk);
        #1;
        holdLine(1'b0, 3 * 2);
        holdLine(1'b1, 3 * bitCycles(16'd2));
        checkIdleOutputs("glitch");
        applyStimulus(mkVec(8'h5A, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'h5A, 1'b0, 1'b0, 1'b0), -1);
        popCheck("after_glitch", 8'h5A, 1'b0, 1'b0, 1'b0);

        // Single-tick inverted pulse in the middle of data bit 4.
        applyStimulus(mkVec(8'h00, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'h00, 1'b0, 1'b0, 1'b0), 4);
        popCheck("noise", 8'h00, 1'b0, 1'b0, 1'b0);

        // Line held low for 20 bit times: exactly one break entry.
        @(posedge clk);
        #1;
        holdLine(1'b0, 20 * bitCycles(16'd2));
        holdLine(1'b1, 3 * bitCycles(16'd2));
        @(negedge clk);
        checkOutput("break_count", 32'(rx_count), 32'd1);
        popCheck("break", 8'h00, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        checkOutput("break_count_after_pop", 32'(rx_count), 32'd0);
        applyStimulus(mkVec(8'hC9, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'hC9, 1'b0, 1'b0, 1'b0), -1);
        popCheck("after_break", 8'hC9, 1'b0, 1'b0, 1'b0);

        // Overrun: five frames into a four-deep FIFO with nobody draining.
        for (int i = 1; i <= 5; i++)
            applyStimulus(mkVec(8'(i), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'(i), 1'b0, 1'b0, 1'b0), -1);
        @(negedge clk);
        checkOutput("ovr_count", 32'(rx_count), 32'd4);
        checkOutput("ovr_flag", 32'(rx_overrun), 32'd1);
        for (int i = 1; i <= 4; i++)
            popCheck($sformatf("ovr_drain%0d", i), 8'(i), 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("ovr_sticky", 32'(rx_overrun), 32'd1);
        checkOutput("ovr_drained_valid", 32'(rx_valid), 32'd0);
        ovr_clr = 1'b1;
        @(posedge clk);
        #1 ovr_clr = 1'b0;
        @(negedge clk);
        checkOutput("ovr_cleared", 32'(rx_overrun), 32'd0);

        // Full FIFO with a pop in the very cycle the fifth entry is pushed.
        for (int i = 0; i < 4; i++)
            applyStimulus(mkVec(8'h11 + 8'(i), 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2,
                                8'h11 + 8'(i), 1'b0, 1'b0, 1'b0), -1);
        fork
            applyStimulus(mkVec(8'h15, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'h15, 1'b0, 1'b0, 1'b0), -1);
            begin
                seen = 0;
                n    = 0;
                while (seen == 0 && n < 3000) begin
                    @(negedge clk);
                    if (dut.push_req)
                        seen = 1;
                    n++;
                end
                checkOutput("full_push_seen", 32'(seen), 32'd1);
                if (seen == 1) begin
                    rx_ready = 1'b1;
                    @(posedge clk);
                    #1 rx_ready = 1'b0;
                end
            end
        join
        @(negedge clk);
        checkOutput("full_count", 32'(rx_count), 32'd4);
        checkOutput("full_no_overrun", 32'(rx_overrun), 32'd0);
        for (int i = 2; i <= 5; i++)
            popCheck($sformatf("full_drain%0d", i), 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0);

        // Reset in the middle of DATA with an entry already queued.
        applyStimulus(mkVec(8'h21, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'h21, 1'b0, 1'b0, 1'b0), -1);
        @(posedge clk);
        #1;
        holdLine(1'b0, bitCycles(16'd2));
        holdLine(1'b1, bitCycles(16'd2));
        holdLine(1'b0, bitCycles(16'd2));
        holdLine(1'b1, bitCycles(16'd2) / 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checkIdleOutputs("midreset");
        holdLine(1'b1, 2 * bitCycles(16'd2));
        applyStimulus(mkVec(8'hE7, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 8'hE7, 1'b0, 1'b0, 1'b0), -1);
        @(negedge clk);
        checkOutput("midreset_next_count", 32'(rx_count), 32'd1);
        popCheck("midreset_next", 8'hE7, 1'b0, 1'b0, 1'b0);

        // Randomized frames scored against the frame-level model.
        for (int i = 0; i < 12; i++) begin
            logic [7:0] d;
            logic [1:0] m;
            logic       pb;
            d  = 8'($urandom);
            m  = 2'($urandom_range(0, 3));
            pb = (m == 2'd1) ? ~^d : ^d;
            if ($urandom_range(0, 3) == 0)
                pb = ~pb;
            v = mkVec(d, m, pb, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0), 16'($urandom_range(1, 3)),
                      8'd0, 1'b0, 1'b0, 1'b0);
            v = withExpected(v);
            applyStimulus(v, -1);
            @(negedge clk);
            checkOutput($sformatf("rand%0d_count", i), 32'(rx_count), 32'd1);
            popCheck($sformatf("rand%0d", i), v.exp_data, v.exp_perr, v.exp_ferr, v.exp_brk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
